// File: rtl/link_pkg.sv
// Link protocol characters shared with the UART sender, plus the round FSM encoding.
// Encoding is visible on link_state for on-screen debug, so values are fixed.
package link_pkg;
    localparam logic [7:0] CHAR_R = 8'h52;
    localparam logic [7:0] CHAR_L = 8'h4C;

    localparam int LINK_STATE_W = 3;
    localparam logic [LINK_STATE_W-1:0] IDLE      = 3'd0;
    localparam logic [LINK_STATE_W-1:0] WAIT_PEER = 3'd1;
    localparam logic [LINK_STATE_W-1:0] PLAYING   = 3'd2;
    localparam logic [LINK_STATE_W-1:0] WIN       = 3'd3;
    localparam logic [LINK_STATE_W-1:0] LOSE      = 3'd4;
endpackage

// File: rtl/peer_ready_watchdog.sv
// Peer-ready flag: set by a kick, dropped TIMEOUT_CYCLES after the last kick; clear has priority.
// One cycle from kick/clear to ready; counter saturates once the timeout has elapsed.
module peer_ready_watchdog #(
    parameter int TIMEOUT_CYCLES = 32_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic kick,
    output logic ready
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // ready falls on the same edge the count reaches LAST, i.e. TIMEOUT_CYCLES after the kick
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt   <= '0;
            ready <= 1'b0;
        end else if (kick) begin
            cnt   <= '0;
            ready <= 1'b1;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST - 1'b1) begin
                ready <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/uart_link_ctrl.sv
// Drains the UART rx FIFO, decodes 'R'/'L' and runs the multiplayer round FSM; all outputs registered.
// A byte is accepted when rx_empty=0 and no pop is pending, so pops are at least two cycles apart.
module uart_link_ctrl
    import link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32_500_000,
    parameter int BAD_CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_empty,
    input  logic [7:0]              r_data,
    input  logic                    multiplayer,
    input  logic                    player_ready,
    input  logic                    game_over,
    output logic                    rd_uart,
    output logic                    game_start,
    output logic                    opponent_ready,
    output logic                    opponent_lost,
    output logic [LINK_STATE_W-1:0] link_state,
    output logic [BAD_CNT_W-1:0]    bad_byte_cnt
);
    logic                    accept;
    logic                    r_hit;
    logic                    l_hit;
    logic                    peer_ok;
    logic                    ready_rise;
    logic                    player_ready_q;
    logic [LINK_STATE_W-1:0] state_nxt;
    logic                    game_start_nxt;
    logic                    opponent_lost_nxt;

    assign accept     = !rx_empty && !rd_uart;
    assign r_hit      = accept && (r_data == CHAR_R);
    assign l_hit      = accept && (r_data == CHAR_L);
    // an 'R' accepted this cycle counts immediately so game_start lands one cycle after acceptance
    assign peer_ok    = opponent_ready || r_hit;
    assign ready_rise = player_ready && !player_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_uart        <= 1'b0;
            player_ready_q <= 1'b0;
            bad_byte_cnt   <= '0;
        end else begin
            rd_uart        <= accept;
            player_ready_q <= player_ready;
            if (accept && !r_hit && !l_hit && (bad_byte_cnt != '1)) begin
                bad_byte_cnt <= bad_byte_cnt + 1'b1;
            end
        end
    end

    peer_ready_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk  (clk),
        .rst  (rst),
        .clear(!multiplayer),
        .kick (r_hit),
        .ready(opponent_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            link_state <= IDLE;
        end else begin
            link_state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = link_state;
        if (!multiplayer) begin
            state_nxt = IDLE;
        end else begin
            case (link_state)
                IDLE:      if (player_ready) state_nxt = WAIT_PEER;
                WAIT_PEER: begin
                    if (!player_ready) state_nxt = IDLE;
                    else if (peer_ok)  state_nxt = PLAYING;
                end
                // a local loss outranks a simultaneous peer 'L': ours is already on the wire
                PLAYING: begin
                    if (game_over)  state_nxt = LOSE;
                    else if (l_hit) state_nxt = WIN;
                end
                WIN, LOSE: if (ready_rise) state_nxt = WAIT_PEER;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        game_start_nxt    = (link_state == WAIT_PEER) && (state_nxt == PLAYING);
        opponent_lost_nxt = (state_nxt == WIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            game_start    <= 1'b0;
            opponent_lost <= 1'b0;
        end else begin
            game_start    <= game_start_nxt;
            opponent_lost <= opponent_lost_nxt;
        end
    end
endmodule

// File: tb/tb_uart_link_ctrl.sv
// Directed and random stimulus against a timestamp-based reference model with a per-cycle scoreboard.
module tb_uart_link_ctrl;
    localparam int T = 16;

    logic       clk;
    logic       rst;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       multiplayer;
    logic       player_ready;
    logic       game_over;
    logic       rd_uart;
    logic       game_start;
    logic       opponent_ready;
    logic       opponent_lost;
    logic [2:0] link_state;
    logic [7:0] bad_byte_cnt;

    uart_link_ctrl #(
        .TIMEOUT_CYCLES(T),
        .BAD_CNT_W     (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_empty      (rx_empty),
        .r_data        (r_data),
        .multiplayer   (multiplayer),
        .player_ready  (player_ready),
        .game_over     (game_over),
        .rd_uart       (rd_uart),
        .game_start    (game_start),
        .opponent_ready(opponent_ready),
        .opponent_lost (opponent_lost),
        .link_state    (link_state),
        .bad_byte_cnt  (bad_byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rd;
        bit start;
        bit ready;
        bit lost;
        int st;
        int bad;
    } exp_t;

    exp_t     expq[$];
    byte      fifo[$];
    int       errors = 0;
    int       checks = 0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: states 0 idle, 1 wait, 2 playing, 3 win, 4 lose.
    // Peer readiness is derived from the timestamp of the last accepted 'R'.
    int  cyc = 0;
    int  last_r = -1;
    int  m_st = 0;
    int  m_bad = 0;
    bit  m_rd = 0;
    bit  m_start = 0;
    bit  m_ready = 0;
    bit  m_lost = 0;
    bit  m_prq = 0;

    always @(posedge clk) begin
        bit  acc;
        bit  rh;
        bit  lh;
        int  nxt;
        byte b;
        if (rst) begin
            m_st = 0; m_bad = 0; m_rd = 0; m_start = 0; m_ready = 0; m_lost = 0;
            m_prq = 0; last_r = -1;
        end else begin
            acc = (fifo.size() > 0) && !m_rd;
            b   = acc ? fifo[0] : 8'h00;
            rh  = acc && (b == 8'h52);
            lh  = acc && (b == 8'h4C);
            if (acc && !rh && !lh && m_bad < 255) m_bad++;
            nxt = m_st;
            if (!multiplayer) nxt = 0;
            else case (m_st)
                0: if (player_ready) nxt = 1;
                1: if (!player_ready) nxt = 0; else if (m_ready || rh) nxt = 2;
                2: if (game_over) nxt = 4; else if (lh) nxt = 3;
                default: if (player_ready && !m_prq) nxt = 1;
            endcase
            m_start = (m_st == 1) && (nxt == 2);
            if (nxt == 3 && m_st == 2) m_lost = 1;
            else if (nxt != 3) m_lost = 0;
            if (!multiplayer) last_r = -1;
            else if (rh) last_r = cyc;
            m_ready = (last_r >= 0) && ((cyc + 1 - last_r) < T);
            m_st  = nxt;
            m_rd  = acc;
            m_prq = player_ready;
        end
        expq.push_back('{m_rd, m_start, m_ready, m_lost, m_st, m_bad});
        cyc++;
        // the FIFO itself reacts to the DUT's pop strobe
        if (rd_uart === 1'b1) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            else check("pop_from_empty", 1, 0);
        end
    end

    bit   prev_rd = 0;
    exp_t e;
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("rd_uart",        int'(rd_uart),        int'(e.rd));
            check("game_start",     int'(game_start),     int'(e.start));
            check("opponent_ready", int'(opponent_ready), int'(e.ready));
            check("opponent_lost",  int'(opponent_lost),  int'(e.lost));
            check("link_state",     int'(link_state),     e.st);
            check("bad_byte_cnt",   int'(bad_byte_cnt),   e.bad);
            check("pop_spacing",    int'(prev_rd && rd_uart), 0);
            prev_rd = rd_uart;
        end
    end

    function automatic void refresh();
        rx_empty = (fifo.size() == 0);
        r_data   = (fifo.size() > 0) ? fifo[0] : 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        refresh();
    endtask

    task automatic push(input byte b);
        fifo.push_back(b);
        refresh();
    endtask

    initial begin
        int n_start;
        int n_rd;
        int k;
        rst = 1; multiplayer = 0; player_ready = 0; game_over = 0;
        refresh();
        repeat (3) tick();
        check("reset_state", int'(link_state), 0);
        check("reset_bad",   int'(bad_byte_cnt), 0);
        rst = 0;

        // 'R' with both sides ready starts a round
        multiplayer = 1; player_ready = 1; push(8'h52);
        n_start = 0; n_rd = 0;
        repeat (5) begin
            tick();
            n_start += int'(game_start);
            n_rd    += int'(rd_uart);
        end
        check("t1_start_pulses", n_start, 1);
        check("t1_pops", n_rd, 1);
        check("t1_state", int'(link_state), 2);
        check("t1_ready", int'(opponent_ready), 1);

        // peer 'L' during play is a local win; a later 'R' changes nothing
        push(8'h4C);
        tick();
        check("t2_state", int'(link_state), 3);
        check("t2_lost", int'(opponent_lost), 1);
        push(8'h52);
        repeat (3) tick();
        check("t2_hold_state", int'(link_state), 3);

        // new round, then game_over and 'L' in the same cycle
        player_ready = 0; tick();
        player_ready = 1; push(8'h52);
        repeat (3) tick();
        check("t3_playing", int'(link_state), 2);
        game_over = 1; push(8'h4C);
        tick();
        game_over = 0;
        check("t3_state", int'(link_state), 4);
        check("t3_lost", int'(opponent_lost), 0);

        // watchdog: a single 'R' then silence
        repeat (20) tick();
        push(8'h52);
        k = 0;
        do begin
            tick();
            k++;
        end while (k < 2 || (opponent_ready && k < 40));
        check("t4_timeout_cycles", k, T);

        // drop multiplayer in PLAYING
        player_ready = 0; tick();
        player_ready = 1; push(8'h52);
        repeat (3) tick();
        check("t5_playing", int'(link_state), 2);
        multiplayer = 0; tick();
        check("t5_state", int'(link_state), 0);
        check("t5_ready", int'(opponent_ready), 0);
        check("t5_lost", int'(opponent_lost), 0);
        check("t5_start", int'(game_start), 0);
        multiplayer = 1; player_ready = 0;

        // 300 unknown bytes saturate the counter
        for (int i = 0; i < 300; i++) fifo.push_back(8'h41);
        refresh();
        k = 0;
        while (fifo.size() > 0 && k < 2000) begin
            tick();
            k++;
        end
        check("t6_drain_in_budget", int'(k < 2000), 1);
        repeat (2) tick();
        check("t6_fifo_empty", fifo.size(), 0);
        check("t6_bad_sat", int'(bad_byte_cnt), 255);

        // reset in the acceptance cycle drops the pop; byte is taken again after reset
        push(8'h52); rst = 1;
        tick();
        rst = 0;
        check("t7_rd_uart", int'(rd_uart), 0);
        check("t7_bad", int'(bad_byte_cnt), 0);
        check("t7_fifo_kept", fifo.size(), 1);
        repeat (3) tick();
        check("t7_fifo_drained", fifo.size(), 0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            int sel;
            multiplayer = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 7) == 0) player_ready = ~player_ready;
            game_over = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 149) == 0);
            if (fifo.size() < 4 && $urandom_range(0, 2) == 0) begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0:       push(8'h52);
                    1:       push(8'h4C);
                    2:       push(8'h41);
                    default: push(8'($urandom_range(0, 255)));
                endcase
            end
            tick();
        end
        rst = 0; game_over = 0;
        repeat (3) tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
